multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle successor to the single-cycle opcode decoder. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback steps over 3–5 cycles. It waits on a memory ready handshake and reports an unresponsive memory through a sticky bus fault. It sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut).

## Interface
Parameters:
- ALUOP_W, 3: width of alu_op. Codes are ADD=0, SUB=1, FUNCT=2, zero-extended to ALUOP_W (ALUOP_W ≥ 2).
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready; 0 disables the timeout.

Ports (a zero-valued output means deasserted):
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_eq  out  1  PC load if ALU zero (br.eq)
- pc_write_ne  out  1  PC load if ALU not zero (br.neq)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 0 rt, 1 rd
- link  out  1  write r31 with PC (overrides reg_dst and mem_to_reg)
- mem_to_reg  out  1  write-back data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  ALUOP_W  ALU operation code
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode
- bus_error  out  1  sticky; high in FAULT
- state  out  4  current state encoding (debug)

## Operation
- Opcodes: R=000000, ADDI=001000, LW=100011, SW=101011, BEQ=010101, BNE=010100, J=000010, JAL=000011.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, FAULT=15.
- Outputs are a pure function of the registered state (and opcode, mem_ready where noted). Any output not listed for a state is 0.
- FETCH:
  - mem_read=1; alu_src_b=01; alu_op=ADD.
  - ir_write=pc_write=mem_ready.
  - Holds in FETCH while !mem_ready; goes to DECODE on mem_ready.
- DECODE:
  - alu_src_b=11; alu_op=ADD (precomputes the branch target).
  - Next state: R→EXEC, ADDI→ADDI_EX, LW/SW→MEM_ADDR, BEQ/BNE→BRANCH, J/JAL→JUMP.
  - Any other opcode: illegal_op=1, instr_done=1, next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready; on mem_ready, instr_done=1 and next FETCH.
- EXEC: alu_src_a=1, alu_op=FUNCT. Next ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, instr_done=1. Next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next ADDI_WB.
- ADDI_WB: reg_write=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_op=SUB, pc_source=01, instr_done=1. Asserts pc_write_eq (BEQ) or pc_write_ne (BNE). Next FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. For JAL also reg_write=1 and link=1. Next FETCH.
- Wait counter:
  - Width $clog2(MEM_TIMEOUT+1).
  - Clears on every state change; increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - With MEM_TIMEOUT>0, a cycle with counter==MEM_TIMEOUT and mem_ready=0 moves to FAULT.
  - mem_ready in that same cycle wins: the access completes normally.
- FAULT: bus_error=1, all other outputs 0. Held until reset.

## Timing
- reset sampled high: next state=FETCH, counter=0. While reset is high, every output is forced to 0 and state reads 0.
- First fetch request (mem_read=1) appears in the first cycle after reset deasserts.
- Cycles per instruction with zero-wait memory (mem_ready=1 whenever requested): LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J/JAL 3, illegal 2. Each memory wait cycle adds 1.
- pc_write/ir_write in FETCH are asserted only in the mem_ready cycle, so PC and IR update exactly once per fetch.
- instr_done asserts in exactly one cycle per instruction, the cycle before re-entering FETCH.
- Reset asserted mid-instruction (including during a wait or in FAULT) aborts it; no write strobe is asserted during the reset cycle.

## Test plan
- Reset, then mem_ready=1 constantly; feed opcodes R, LW, SW, BEQ, J → state sequences 0-1-6-7, 0-1-2-3-4, 0-1-2-5, 0-1-8, 0-1-9. instr_done pulses at cycles 4, 9, 13, 16, 19.
- LW with mem_ready low for 3 cycles in MEM_RD → state holds 3 for 4 cycles; mem_read=1, i_or_d=1 throughout; reg_write=1 only in MEM_WB.
- MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH → FAULT entered after 16 FETCH cycles, bus_error=1 and held. Pulsing reset returns state=0, bus_error=0.
- mem_ready rises in the same cycle counter==MEM_TIMEOUT → no FAULT; DECODE follows.
- Opcode 111111 → illegal_op and instr_done high for one cycle in DECODE; next state FETCH.
- BNE → pc_write_ne=1, pc_write_eq=0, pc_source=01, alu_op=1. JAL → reg_write=1, link=1, pc_write=1, pc_source=10. Reset asserted in MEM_WR → mem_write=0 that cycle and state=0 next.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: a Moore FSM that walks each instruction through
// fetch/decode/execute/memory/writeback, waits on mem_ready, and parks in a
// sticky FAULT state when memory stops answering.
// Ports: clk, reset (sync, active-high); opcode (IR[31:26]); mem_ready;
// datapath controls (pc_write*, pc_source, i_or_d, mem_read/write, ir_write,
// reg_dst, link, mem_to_reg, reg_write, alu_src_a/b, alu_op);
// status (instr_done, illegal_op, bus_error, state).
module multicycle_control_unit #(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               link,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               bus_error,
  output logic [3:0]         state
);

  // Counter must hold MEM_TIMEOUT; keep one bit when the timeout is disabled.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b010101;
  localparam logic [5:0] OP_BNE  = 6'b010100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_FAULT    = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait counter and Moore output decode
  always_comb begin
    state_d     = state_q;
    waiting     = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_source   = 2'b00;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    link        = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    bus_error   = 1'b0;
    state       = 4'(state_q);

    case (state_q)
      S_FETCH: begin
        waiting   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // PC/IR load only in the completing cycle so each fetch updates once
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R:          state_d = S_EXEC;
          OP_ADDI:       state_d = S_ADDI_EX;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:  state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        waiting  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        waiting   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = ALU_SUB;
        pc_source   = 2'b01;
        pc_write_eq = (opcode == OP_BEQ);
        pc_write_ne = (opcode == OP_BNE);
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = (opcode == OP_JAL);
        link       = (opcode == OP_JAL);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: begin
        bus_error = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Timeout only fires when memory is still silent; a late ready wins
    if ((MEM_TIMEOUT != 0) && waiting && !mem_ready &&
        (cnt_q == CNT_W'(MEM_TIMEOUT)))
      state_d = S_FAULT;

    if (state_d != state_q)
      cnt_d = '0;
    else if (waiting && !mem_ready)
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;

    // Reset cycle: nothing leaves the block, so no write strobe can fire
    if (reset) begin
      pc_write    = 1'b0;
      pc_write_eq = 1'b0;
      pc_write_ne = 1'b0;
      pc_source   = 2'b00;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      link        = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = '0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      bus_error   = 1'b0;
      state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: per-instruction expectations (state path and strobe
// counts) are queued at issue time and compared when instr_done pulses.
module tb_multicycle_control_unit;
  localparam int unsigned ALUOP_W     = 3;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int NF      = 18;
  localparam int N_RAND  = 60;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b010101;
  localparam logic [5:0] OP_BNE  = 6'b010100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write;
  logic ir_write, reg_dst, link, mem_to_reg, reg_write, alu_src_a;
  logic instr_done, illegal_op, bus_error;
  logic [1:0] pc_source, alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [3:0] state;

  multicycle_control_unit #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .link(link),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          waitq[$];
  logic [5:0]  opq[$];
  int          expf[$];
  string       exps[$];
  string       expn[$];
  bit          force_nr = 1'b0;
  bit          mon_en   = 1'b0;
  int          cur_wait = 0;
  bit          active   = 1'b0;

  string fn [NF] = '{"cycles", "mem_read", "mem_write", "i_or_d", "ir_write",
                     "pc_write", "reg_write", "link", "mem_to_reg", "reg_dst",
                     "pc_write_eq", "pc_write_ne", "illegal_op", "alu_src_a",
                     "alu_src_b_sum", "pc_source_sum", "alu_op_sum", "bus_error"};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic others();
    return |{pc_write, pc_write_eq, pc_write_ne, pc_source, i_or_d, mem_read,
             mem_write, ir_write, reg_dst, link, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
  endfunction

  // Reference: expected state path and per-instruction strobe totals
  task automatic model(input logic [5:0] op, input int wf, input int wm, input string nm);
    int e [NF];
    string p;
    bit r, ad, lw, sw, beq, bne, j, jal, br, jj, ill;
    r = (op == OP_R); ad = (op == OP_ADDI); lw = (op == OP_LW); sw = (op == OP_SW);
    beq = (op == OP_BEQ); bne = (op == OP_BNE); j = (op == OP_J); jal = (op == OP_JAL);
    br = beq || bne; jj = j || jal; ill = !is_legal(op);
    p = "";
    for (int i = 0; i <= wf; i++) p = {p, "0"};
    p = {p, "1"};
    if (r)  p = {p, "67"};
    if (ad) p = {p, "ab"};
    if (lw) begin
      p = {p, "2"};
      for (int i = 0; i <= wm; i++) p = {p, "3"};
      p = {p, "4"};
    end
    if (sw) begin
      p = {p, "2"};
      for (int i = 0; i <= wm; i++) p = {p, "5"};
    end
    if (br) p = {p, "8"};
    if (jj) p = {p, "9"};
    e[0]  = p.len();
    e[1]  = wf + 1 + (lw ? wm + 1 : 0);
    e[2]  = sw ? wm + 1 : 0;
    e[3]  = (lw || sw) ? wm + 1 : 0;
    e[4]  = 1;
    e[5]  = 1 + (jj ? 1 : 0);
    e[6]  = (r || ad || lw || jal) ? 1 : 0;
    e[7]  = jal ? 1 : 0;
    e[8]  = lw ? 1 : 0;
    e[9]  = r ? 1 : 0;
    e[10] = beq ? 1 : 0;
    e[11] = bne ? 1 : 0;
    e[12] = ill ? 1 : 0;
    e[13] = (r || ad || lw || sw || br) ? 1 : 0;
    e[14] = (wf + 1) + 3 + ((ad || lw || sw) ? 2 : 0);
    e[15] = br ? 1 : (jj ? 2 : 0);
    e[16] = br ? 1 : (r ? 2 : 0);
    e[17] = 0;
    for (int i = 0; i < NF; i++) expf.push_back(e[i]);
    exps.push_back(p);
    expn.push_back(nm);
  endtask

  task automatic issue(input logic [5:0] op, input int wf, input int wm, input string nm);
    opq.push_back(op);
    waitq.push_back(wf);
    if (op == OP_LW || op == OP_SW) waitq.push_back(wm);
    model(op, wf, wm, nm);
  endtask

  // Memory: answers each request after its queued wait count; hands the
  // next opcode to the IR when an instruction fetch completes.
  always @(negedge clk) begin
    if (reset) begin
      active    = 1'b0;
      mem_ready = 1'b0;
    end else if (force_nr) begin
      mem_ready = 1'b0;
    end else if (mem_read || mem_write) begin
      if (!active) begin
        cur_wait = (waitq.size() > 0) ? waitq.pop_front() : 0;
        active   = 1'b1;
      end
      if (cur_wait == 0) begin
        mem_ready = 1'b1;
        active    = 1'b0;
        if (mem_read && !i_or_d && opq.size() > 0) opcode = opq.pop_front();
      end else begin
        mem_ready = 1'b0;
        cur_wait--;
      end
    end else begin
      mem_ready = 1'b0;
    end
  end

  // Monitor: accumulate per-instruction observations, compare on instr_done
  int    obs [NF];
  string obs_path = "";
  always @(negedge clk) begin
    string ep, nm;
    #2;
    if (reset || !mon_en) begin
      for (int i = 0; i < NF; i++) obs[i] = 0;
      obs_path = "";
    end else begin
      obs[0]++;
      obs[1]  += int'(mem_read);
      obs[2]  += int'(mem_write);
      obs[3]  += int'(i_or_d);
      obs[4]  += int'(ir_write);
      obs[5]  += int'(pc_write);
      obs[6]  += int'(reg_write);
      obs[7]  += int'(link);
      obs[8]  += int'(mem_to_reg);
      obs[9]  += int'(reg_dst);
      obs[10] += int'(pc_write_eq);
      obs[11] += int'(pc_write_ne);
      obs[12] += int'(illegal_op);
      obs[13] += int'(alu_src_a);
      obs[14] += int'(alu_src_b);
      obs[15] += int'(pc_source);
      obs[16] += int'(alu_op);
      obs[17] += int'(bus_error);
      obs_path = {obs_path, $sformatf("%h", state)};
      if (instr_done) begin
        if (exps.size() == 0) begin
          chk("unexpected_instr_done", 1, 0);
        end else begin
          ep = exps.pop_front();
          nm = expn.pop_front();
          n_tests++;
          if (obs_path != ep) begin
            n_fail++;
            $display("FAIL %s.path: got %s expected %s", nm, obs_path, ep);
          end
          for (int i = 0; i < NF; i++) chk({nm, ".", fn[i]}, obs[i], expf.pop_front());
        end
        for (int i = 0; i < NF; i++) obs[i] = 0;
        obs_path = "";
      end
    end
  end

  task automatic start_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    waitq.delete();
    opq.delete();
  endtask

  task automatic end_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int sel, wf, wm, rr, cnt;
    ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'(others()), 0);
    chk("reset_bus_error", int'(bus_error), 0);

    // Zero-wait reference sequence, then randomized traffic
    start_reset();
    issue(OP_R,   0, 0, "seq_R");
    issue(OP_LW,  0, 0, "seq_LW");
    issue(OP_SW,  0, 0, "seq_SW");
    issue(OP_BEQ, 0, 0, "seq_BEQ");
    issue(OP_J,   0, 0, "seq_J");
    for (int k = 0; k < N_RAND; k++) begin
      sel = $urandom_range(0, 8);
      if (sel < 8) op = ops[sel];
      else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      rr = $urandom_range(0, 9);
      wf = (rr < 5) ? 0 : (rr < 8) ? rr - 4 : (rr == 8) ? 15 : 14;
      rr = $urandom_range(0, 9);
      wm = (rr < 5) ? 0 : rr - 5;
      issue(op, wf, wm, $sformatf("r%0d_op%b", k, op));
    end
    mon_en = 1'b1;
    end_reset();
    cnt = 0;
    while (exps.size() > 0 && cnt < 20000) begin
      @(posedge clk);
      cnt++;
    end
    chk("scoreboard_drained", exps.size(), 0);
    mon_en = 1'b0;

    // Memory stuck low in FETCH: FAULT after 16 FETCH cycles, sticky
    start_reset();
    force_nr = 1'b1;
    end_reset();
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #2;
      if (state == 4'd15) break;
      if (state == 4'd0) cnt++;
    end
    chk("fault_fetch_cycles", cnt, 16);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #2;
      chk("fault_state_held", int'(state), 15);
      chk("fault_bus_error", int'(bus_error), 1);
      chk("fault_outputs_zero", int'(others()), 0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #2;
    chk("fault_reset_state", int'(state), 0);
    chk("fault_reset_bus_error", int'(bus_error), 0);
    @(posedge clk); #1 reset = 1'b0;
    force_nr = 1'b0;
    @(negedge clk); #2;
    chk("post_fault_state", int'(state), 0);
    chk("post_fault_bus_error", int'(bus_error), 0);
    chk("post_fault_mem_read", int'(mem_read), 1);

    // Ready arrives exactly when the counter hits the limit: no fault
    start_reset();
    opq.push_back(OP_R);
    waitq.push_back(15);
    end_reset();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #2;
      if (state != 4'd0) break;
      cnt++;
    end
    chk("edge_fetch_cycles", cnt, 16);
    chk("edge_next_state", int'(state), 1);
    chk("edge_bus_error", int'(bus_error), 0);

    // Reset during a stalled store aborts it with no write strobe
    start_reset();
    opq.push_back(OP_SW);
    waitq.push_back(0);
    waitq.push_back(10);
    end_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #2;
      if (state == 4'd5) break;
    end
    chk("sw_reached_mem_wr", int'(state), 5);
    chk("sw_mem_write_active", int'(mem_write), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #2;
    chk("sw_reset_mem_write", int'(mem_write), 0);
    chk("sw_reset_outputs", int'(others()), 0);
    chk("sw_reset_state", int'(state), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #2;
    chk("sw_after_reset_state", int'(state), 0);
    chk("sw_after_reset_mem_read", int'(mem_read), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
